// File: rtl/snake_move_ctrl.sv
// Snake body store and move sequencer: wall check, serial self-collision scan,
// then a one-cycle shift of the segment arrays with optional growth.
module snake_move_ctrl #(
    parameter int MAX_LEN = 20,
    parameter int COORD_W = 6,
    parameter int GRID_W  = 32,
    parameter int GRID_H  = 24
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       tick,
    input  logic [1:0]                 dir,
    input  logic                       restart,
    input  logic [COORD_W-1:0]         food_x,
    input  logic [COORD_W-1:0]         food_y,
    input  logic                       food_valid,
    output logic [MAX_LEN*COORD_W-1:0] body_x,
    output logic [MAX_LEN*COORD_W-1:0] body_y,
    output logic [MAX_LEN-1:0]         body_en,
    output logic [4:0]                 length,
    output logic                       busy,
    output logic                       done,
    output logic                       ate,
    output logic                       hit_wall,
    output logic                       hit_self,
    output logic                       game_over
);

    typedef enum logic [2:0] {S_IDLE, S_CALC, S_SCAN, S_UPDATE, S_OVER} state_t;
    typedef enum logic [1:0] {DIR_UP, DIR_RIGHT, DIR_DOWN, DIR_LEFT} dir_t;

    localparam logic [4:0]       LEN_MAX  = 5'(MAX_LEN);
    localparam logic [4:0]       IDX_LAST = 5'(MAX_LEN - 1);
    localparam logic [COORD_W:0] X_LIM    = (COORD_W + 1)'(GRID_W);
    localparam logic [COORD_W:0] Y_LIM    = (COORD_W + 1)'(GRID_H);

    function automatic logic [COORD_W-1:0] init_x(input int i);
        return (i < 3) ? COORD_W'(GRID_W / 2 - i) : '0;
    endfunction

    function automatic logic [COORD_W-1:0] init_y(input int i);
        return (i < 3) ? COORD_W'(GRID_H / 2) : '0;
    endfunction

    state_t               state_q, state_d;
    dir_t                 dir_q, dir_d;
    logic [COORD_W-1:0]   seg_x_q [MAX_LEN];
    logic [COORD_W-1:0]   seg_x_d [MAX_LEN];
    logic [COORD_W-1:0]   seg_y_q [MAX_LEN];
    logic [COORD_W-1:0]   seg_y_d [MAX_LEN];
    logic [MAX_LEN-1:0]   en_q, en_d;
    logic [4:0]           len_q, len_d;
    logic [4:0]           idx_q, idx_d;
    logic [COORD_W-1:0]   cand_x_q, cand_x_d, cand_y_q, cand_y_d;
    logic                 eat_q, eat_d;
    logic                 done_q, done_d, ate_q, ate_d;
    logic                 wall_q, wall_d, self_q, self_d, over_q, over_d;

    // One extra bit lets a step off either edge (0-1 or LIM) fail one unsigned compare.
    logic [COORD_W:0]     step_x, step_y;
    logic                 step_wall;

    always_comb begin
        step_x = {1'b0, seg_x_q[0]};
        step_y = {1'b0, seg_y_q[0]};
        unique case (dir_q)
            DIR_UP:    step_y = step_y - 1'b1;
            DIR_RIGHT: step_x = step_x + 1'b1;
            DIR_DOWN:  step_y = step_y + 1'b1;
            DIR_LEFT:  step_x = step_x - 1'b1;
        endcase
        step_wall = (step_x >= X_LIM) || (step_y >= Y_LIM);
    end

    always_comb begin
        // NOTE: every _d starts from its _q (pulses from 0) so no branch can infer a latch.
        state_d  = state_q;
        dir_d    = dir_q;
        seg_x_d  = seg_x_q;
        seg_y_d  = seg_y_q;
        en_d     = en_q;
        len_d    = len_q;
        idx_d    = idx_q;
        cand_x_d = cand_x_q;
        cand_y_d = cand_y_q;
        eat_d    = eat_q;
        done_d   = 1'b0;
        ate_d    = 1'b0;
        wall_d   = wall_q;
        self_d   = self_q;
        over_d   = over_q;

        case (state_q)
            S_IDLE: if (tick) begin
                if (dir_t'(dir) != dir_t'(dir_q ^ 2'b10)) dir_d = dir_t'(dir);
                state_d = S_CALC;
            end
            S_CALC: begin
                if (step_wall) begin
                    wall_d  = 1'b1;
                    over_d  = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_OVER;
                end else begin
                    cand_x_d = step_x[COORD_W-1:0];
                    cand_y_d = step_y[COORD_W-1:0];
                    eat_d    = food_valid && (step_x[COORD_W-1:0] == food_x)
                                          && (step_y[COORD_W-1:0] == food_y);
                    idx_d    = 5'd1;
                    state_d  = S_SCAN;
                end
            end
            S_SCAN: begin
                if (en_q[idx_q] && seg_x_q[idx_q] == cand_x_q && seg_y_q[idx_q] == cand_y_q) begin
                    self_d  = 1'b1;
                    over_d  = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_OVER;
                end else if (idx_q == IDX_LAST) begin
                    state_d = S_UPDATE;
                end else begin
                    idx_d = idx_q + 5'd1;
                end
            end
            S_UPDATE: begin
                for (int i = MAX_LEN - 1; i > 0; i--) begin
                    seg_x_d[i] = seg_x_q[i-1];
                    seg_y_d[i] = seg_y_q[i-1];
                end
                seg_x_d[0] = cand_x_q;
                seg_y_d[0] = cand_y_q;
                en_d       = {en_q[MAX_LEN-2:0], 1'b1};
                // Growth keeps the shifted-in tail; otherwise drop the slot just past the tail.
                if (eat_q) begin
                    if (len_q < LEN_MAX) len_d = len_q + 5'd1;
                end else if (len_q < LEN_MAX) begin
                    en_d[len_q] = 1'b0;
                end
                done_d  = 1'b1;
                ate_d   = eat_q;
                state_d = S_IDLE;
            end
            S_OVER:  state_d = S_OVER;
            default: state_d = S_IDLE;
        endcase

        if (restart) begin
            state_d = S_IDLE;
            dir_d   = DIR_RIGHT;
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_d[i] = init_x(i);
                seg_y_d[i] = init_y(i);
            end
            en_d     = MAX_LEN'(3'b111);
            len_d    = 5'd3;
            idx_d    = '0;
            cand_x_d = '0;
            cand_y_d = '0;
            eat_d    = 1'b0;
            done_d   = 1'b0;
            ate_d    = 1'b0;
            wall_d   = 1'b0;
            self_d   = 1'b0;
            over_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            dir_q   <= DIR_RIGHT;
            // NOTE: the segment arrays are reset too; the renderer needs a defined snake at once.
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_q[i] <= init_x(i);
                seg_y_q[i] <= init_y(i);
            end
            en_q     <= MAX_LEN'(3'b111);
            len_q    <= 5'd3;
            idx_q    <= '0;
            cand_x_q <= '0;
            cand_y_q <= '0;
            eat_q    <= 1'b0;
            done_q   <= 1'b0;
            ate_q    <= 1'b0;
            wall_q   <= 1'b0;
            self_q   <= 1'b0;
            over_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            seg_x_q  <= seg_x_d;
            seg_y_q  <= seg_y_d;
            en_q     <= en_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            cand_x_q <= cand_x_d;
            cand_y_q <= cand_y_d;
            eat_q    <= eat_d;
            done_q   <= done_d;
            ate_q    <= ate_d;
            wall_q   <= wall_d;
            self_q   <= self_d;
            over_q   <= over_d;
        end
    end

    for (genvar g = 0; g < MAX_LEN; g++) begin : g_pack
        assign body_x[g*COORD_W +: COORD_W] = seg_x_q[g];
        assign body_y[g*COORD_W +: COORD_W] = seg_y_q[g];
    end

    assign body_en   = en_q;
    assign length    = len_q;
    assign busy      = (state_q == S_CALC) || (state_q == S_SCAN) || (state_q == S_UPDATE);
    assign done      = done_q;
    assign ate       = ate_q;
    assign hit_wall  = wall_q;
    assign hit_self  = self_q;
    assign game_over = over_q;

endmodule
